// File: rtl/sha2_msg_padder.sv
// SHA-2 message padder: inserts the 0x80 marker, zero fill and big-endian bit-length
// into a word stream and emits complete 16-word blocks to the compression engine.
module sha2_msg_padder #(
    parameter  int WORD_W = 32,
    parameter  int LEN_W  = 64,
    localparam int NB_W   = $clog2(WORD_W/8) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [NB_W-1:0]   in_nbytes,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_widx,
    output logic              out_last_blk,
    output logic              busy
);
    localparam int NB = WORD_W / 8;

    typedef enum logic [2:0] {S_DATA, S_PAD80, S_ZERO, S_LEN_HI, S_LEN_LO} state_t;

    state_t              r_state, w_nstate;
    logic [WORD_W-1:0]   r_data, w_ld_data;
    logic                r_valid, r_last, r_busy, r_run;
    logic [3:0]          r_widx, w_nidx;
    logic [LEN_W-1:0]    r_len, w_len_nxt;
    logic [2*WORD_W-1:0] w_len_ext;
    logic                w_adv, w_room, w_in_acc, w_load, w_ld_last;

    assign w_adv     = r_valid && out_ready;
    assign w_room    = !r_valid || out_ready;
    // Index the word being loaded this cycle will carry.
    assign w_nidx    = r_widx + {3'b000, w_adv};
    assign in_ready  = r_run && (r_state == S_DATA) && w_room;
    assign w_in_acc  = in_ready && in_valid;
    assign w_len_ext = (2*WORD_W)'(r_len);

    assign out_data     = r_data;
    assign out_valid    = r_valid;
    assign out_widx     = r_widx;
    assign out_last_blk = r_last;
    assign busy         = r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_DATA;
        else      r_state <= w_nstate;
    end

    always_comb begin
        w_nstate  = r_state;
        w_load    = 1'b0;
        w_ld_data = '0;
        w_ld_last = 1'b0;
        w_len_nxt = r_len;
        case (r_state)
            S_DATA: begin
                if (w_in_acc) begin
                    w_load = 1'b1;
                    if (!in_last) begin
                        w_ld_data = in_data;
                        w_len_nxt = r_len + LEN_W'(WORD_W);
                    end else if (in_nbytes >= NB_W'(NB)) begin
                        w_ld_data = in_data;
                        w_len_nxt = r_len + LEN_W'(WORD_W);
                        w_nstate  = S_PAD80;
                    end else begin
                        // Partial final word: keep leading bytes, marker at byte k.
                        for (int b = 0; b < NB; b++) begin
                            if (NB_W'(b) < in_nbytes)
                                w_ld_data[WORD_W-1-8*b -: 8] = in_data[WORD_W-1-8*b -: 8];
                            else if (NB_W'(b) == in_nbytes)
                                w_ld_data[WORD_W-1-8*b -: 8] = 8'h80;
                        end
                        w_len_nxt = r_len + LEN_W'({in_nbytes, 3'b000});
                        w_nstate  = (w_nidx == 4'd13) ? S_LEN_HI : S_ZERO;
                    end
                end
            end
            S_PAD80: begin
                w_load = w_room;
                w_ld_data[WORD_W-1] = 1'b1;
                if (w_room) w_nstate = (w_nidx == 4'd13) ? S_LEN_HI : S_ZERO;
            end
            S_ZERO: begin
                w_load = w_room;
                if (w_room && w_nidx == 4'd13) w_nstate = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_load    = w_room;
                w_ld_data = w_len_ext[2*WORD_W-1:WORD_W];
                if (w_room) w_nstate = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_load    = w_room;
                w_ld_data = w_len_ext[WORD_W-1:0];
                w_ld_last = 1'b1;
                // Length is captured in the output word, so the next message can start now.
                if (w_room) begin
                    w_nstate  = S_DATA;
                    w_len_nxt = '0;
                end
            end
            default: w_nstate = S_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_run   <= 1'b0;
            r_widx  <= '0;
            r_len   <= '0;
        end else begin
            r_run  <= 1'b1;
            r_widx <= w_nidx;
            r_len  <= w_len_nxt;
            r_busy <= (r_busy && !(w_adv && r_last)) || w_in_acc;
            if (w_load) begin
                r_data  <= w_ld_data;
                r_last  <= w_ld_last;
                r_valid <= 1'b1;
            end else if (w_adv) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sha2_msg_padder.sv
// Bench for sha2_msg_padder: 32- and 64-bit instances, byte-level FIPS 180-4 padding
// model feeding a scoreboard queue, checked against every output handshake.
module tb_sha2_msg_padder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        rand_mode = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [3:0]  in_nbytes = '0;
    logic        out_ready;

    logic [31:0] o32_data;
    logic [63:0] o64_data;
    logic        o32_valid, o64_valid, o32_last, o64_last, o32_busy, o64_busy;
    logic        o32_in_ready, o64_in_ready;
    logic [3:0]  o32_widx, o64_widx;

    logic [63:0] m_data;
    logic        m_valid, m_last, m_busy, m_in_ready;
    logic [3:0]  m_widx;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  widx;
        logic        last;
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sha2_msg_padder #(.WORD_W(32), .LEN_W(64)) dut32 (
        .clk(clk), .rst(rst), .in_data(in_data[31:0]), .in_valid(in_valid && !sel),
        .in_ready(o32_in_ready), .in_last(in_last), .in_nbytes(in_nbytes[2:0]),
        .out_data(o32_data), .out_valid(o32_valid), .out_ready(out_ready),
        .out_widx(o32_widx), .out_last_blk(o32_last), .busy(o32_busy));

    sha2_msg_padder #(.WORD_W(64), .LEN_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && sel),
        .in_ready(o64_in_ready), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_data(o64_data), .out_valid(o64_valid), .out_ready(out_ready),
        .out_widx(o64_widx), .out_last_blk(o64_last), .busy(o64_busy));

    assign m_data     = sel ? o64_data : {32'h0, o32_data};
    assign m_valid    = sel ? o64_valid : o32_valid;
    assign m_last     = sel ? o64_last : o32_last;
    assign m_busy     = sel ? o64_busy : o32_busy;
    assign m_in_ready = sel ? o64_in_ready : o32_in_ready;
    assign m_widx     = sel ? o64_widx : o32_widx;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare on handshakes, stability during stalls.
    logic [63:0] p_data;
    logic [3:0]  p_widx;
    logic        p_last;
    logic        p_stall = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (p_stall) begin
                checks++;
                assert ({m_data, m_widx, m_last} === {p_data, p_widx, p_last}) else begin
                    errors++;
                    $error("FAIL stall_hold obs=%h/%0d/%b exp=%h/%0d/%b", m_data, m_widx, m_last, p_data, p_widx, p_last);
                end
            end
            if (m_valid && !out_ready) begin
                checks++;
                assert (m_in_ready === 1'b0) else begin
                    errors++;
                    $error("FAIL in_ready_in_stall obs=%b exp=0", m_in_ready);
                end
            end
            if (m_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    assert (sbq.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_word obs=%h/%0d/%b exp=none", m_data, m_widx, m_last);
                    end
                end else begin
                    e = sbq.pop_front();
                    assert (m_data === e.data && m_widx === e.widx && m_last === e.last) else begin
                        errors++;
                        $error("FAIL out_word obs=%h/%0d/%b exp=%h/%0d/%b", m_data, m_widx, m_last, e.data, e.widx, e.last);
                    end
                end
            end
            p_stall = m_valid && !out_ready;
            p_data  = m_data;
            p_widx  = m_widx;
            p_last  = m_last;
        end
    end

    // Byte-level padding model: message, 0x80, zeros, big-endian length field.
    task automatic push_expected(input logic [7:0] msg[$], input int wb);
        logic [7:0]  q[$];
        logic [63:0] bitlen;
        exp_t        e;
        int          nw;
        q = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        q.push_back(8'h80);
        while ((q.size() % (16*wb)) != (14*wb)) q.push_back(8'h00);
        for (int i = 2*wb - 1; i >= 0; i--) q.push_back(i < 8 ? 8'(bitlen >> (8*i)) : 8'h00);
        nw = q.size() / wb;
        for (int w = 0; w < nw; w++) begin
            e.data = '0;
            for (int j = 0; j < wb; j++) e.data = (e.data << 8) | 64'(q[w*wb + j]);
            e.widx = 4'(w % 16);
            e.last = (w == nw - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic lst, input logic [3:0] nb);
        int t = 0;
        in_data = d; in_last = lst; in_nbytes = nb; in_valid = 1'b1;
        @(negedge clk);
        while (!m_in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        assert (m_in_ready === 1'b1) else begin
            errors++;
            $error("FAIL in_ready_timeout obs=%b exp=1", m_in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Sends msg word by word; bytes past the end of the message are junk (0xFF).
    task automatic send_msg(input logic [7:0] msg[$], input int wb);
        int          n, nw, nb;
        logic [63:0] d;
        n  = msg.size();
        nw = (n == 0) ? 1 : (n + wb - 1) / wb;
        push_expected(msg, wb);
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int j = 0; j < wb; j++)
                d = (d << 8) | 64'((w*wb + j < n) ? msg[w*wb + j] : 8'hFF);
            nb = (w == nw - 1) ? (n - w*wb) : wb;
            send_word(d, w == nw - 1, 4'(nb));
            if (w == 0) begin
                checks++;
                assert (m_busy === 1'b1) else begin
                    errors++;
                    $error("FAIL busy_mid_msg obs=%b exp=1", m_busy);
                end
            end
        end
    endtask

    task automatic wait_drain(input logic exp_busy);
        int t = 0;
        while (sbq.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout obs=%0d exp=0 words left", sbq.size());
        end
        @(posedge clk);
        #1;
        checks++;
        assert (m_busy === exp_busy && m_valid === 1'b0) else begin
            errors++;
            $error("FAIL idle_after_drain obs=busy%b/valid%b exp=busy%b/valid0", m_busy, m_valid, exp_busy);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        assert (m_in_ready === 1'b0 && m_valid === 1'b0 && m_busy === 1'b0 &&
                m_widx === 4'd0 && m_last === 1'b0 && m_data === 64'd0) else begin
            errors++;
            $error("FAIL %s obs=rdy%b/vld%b/busy%b/widx%0d/last%b/data%h exp=all zero",
                   tag, m_in_ready, m_valid, m_busy, m_widx, m_last, m_data);
        end
    endtask

    task automatic release_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_state({tag, "_before_edge"});
        @(negedge clk);
        checks++;
        assert (m_in_ready === 1'b1) else begin
            errors++;
            $error("FAIL %s_ready obs=%b exp=1", tag, m_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] abc[$];
        logic [7:0] empty_msg[$];
        logic [7:0] m56[$];
        logic [7:0] m64[$];
        abc = '{8'h61, 8'h62, 8'h63};
        for (int i = 0; i < 56; i++) m56.push_back(8'(i*13 + 5));
        for (int i = 0; i < 64; i++) m64.push_back(8'(i*7 + 1));

        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0 check_reset_state(s == 0 ? "reset32" : "reset64");
        end
        sel = 1'b0;
        release_reset("release32");

        send_msg(abc, 4);       wait_drain(1'b0);
        send_msg(empty_msg, 4); wait_drain(1'b0);
        send_msg(m56, 4);       wait_drain(1'b0);
        send_msg(m64, 4);       wait_drain(1'b0);
        // Back-to-back messages with no idle gap between them.
        send_msg(abc, 4);
        send_msg(m56, 4);       wait_drain(1'b0);

        rand_mode = 1'b1;
        send_msg(abc, 4);       wait_drain(1'b0);
        send_msg(m56, 4);       wait_drain(1'b0);
        rand_mode = 1'b0;
        @(posedge clk);
        #1;

        sel = 1'b1;
        send_msg(abc, 8);       wait_drain(1'b0);
        for (int w = 0; w < 5; w++) begin
            exp_t e;
            e.data = 64'h0123_4567_89AB_CDEF ^ 64'(w);
            e.widx = 4'(w);
            e.last = 1'b0;
            sbq.push_back(e);
            send_word(e.data, 1'b0, 4'd8);
        end
        wait_drain(1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midmsg_reset64");
        release_reset("rerelease64");
        send_msg(abc, 8);       wait_drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout obs=running exp=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sha2_msg_padder.md
# sha2_msg_padder

Parametrised SHA-2 message padder sitting between the message source and the SHA-2 compression engine. It accepts a byte-granular message as a stream of big-endian words and inserts the 0x80 marker, zero fill and bit-length field per FIPS 180-4. It emits complete 16-word blocks over a valid/ready stream. One instance serves SHA-224/256 (32-bit words) or SHA-384/512 (64-bit words) depending on WORD_W.

## Interface
- WORD_W, 32: word width; 32 gives 512-bit blocks, 64 gives 1024-bit blocks. Only 32 and 64 are legal.
- LEN_W, 64: bit-length counter width, at most 2*WORD_W. The counter is zero-extended into the 2*WORD_W length field.
- NB_W, log2(WORD_W/8)+1: width of in_nbytes (derived, not overridden).
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  WORD_W  message word; first byte is in the MSBs.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  padder accepts the word this cycle.
- in_last  in  1  marks the final word of the message.
- in_nbytes  in  NB_W  valid bytes in the final word, 0..WORD_W/8. Ignored unless in_last=1.
- out_data  out  WORD_W  block word to the engine.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  engine accepts the word.
- out_widx  out  4  index of out_data within its block, 0..15.
- out_last_blk  out  1  high only on word 15 of the message's final block.
- busy  out  1  a message is in progress: from the first accepted word until the final length word handshake.

## Operation
- Word handshake = valid && ready on the same edge. Byte handshake is not used.
- FSM states: S_DATA, S_PAD80, S_ZERO, S_LEN_HI, S_LEN_LO.
- S_DATA: in_ready = !out_valid || out_ready. Each accepted word loads the output register.
  - Non-last word: emitted unchanged; len += WORD_W.
  - in_last with k = in_nbytes < NB: bytes 0..k-1 are kept, byte k = 0x80, the rest is zero; len += 8k. Next state is S_ZERO, or S_LEN_HI if this word sits at widx 13.
  - k = 0: in_data is ignored and the word is 0x80 followed by zeros (this covers the empty message).
  - in_last with k = NB: emitted unchanged; len += WORD_W; next state S_PAD80.
- S_PAD80: emits the word with only the MSB set, then goes to S_ZERO, or S_LEN_HI if that word sits at widx 13.
- S_ZERO: emits zero words until the emitted widx is 13, then goes to S_LEN_HI.
  - If the 0x80-carrying word landed at widx 14 or 15, zero fill continues through 15 and wraps into a fresh block at widx 0..13.
- S_LEN_HI emits len_ext[2W-1:W]; S_LEN_LO emits len_ext[W-1:0] with out_last_blk=1. Here len_ext is len zero-extended to 2*WORD_W.
- After the S_LEN_LO handshake: len and widx clear to 0, return to S_DATA.
- in_ready = 0 in every state except S_DATA.
- out_widx increments on each output handshake and wraps 15→0.
- len wraps modulo 2^LEN_W with no error flag.

## Timing
- Async reset values: state S_DATA, out_valid 0, out_data 0, out_widx 0, out_last_blk 0, busy 0, len 0.
  - in_ready = 0 while rst is low, and 1 on the first edge after release.
- Latency is 1 cycle from input handshake to out_valid.
- Throughput is one word per cycle with out_ready held high, including pad and length words. There are no bubbles between blocks or between messages.
- Backpressure: while out_valid && !out_ready, out_data, out_widx and out_last_blk hold stable and in_ready = 0.
- Reset mid-message aborts the message: no partial block completion. The next message starts at widx 0.
- in_valid is ignored outside S_DATA. The source must hold the word until in_ready.

## Test plan
- WORD_W=32, "abc" (one word 0x61626300, in_last, nbytes=3) → 0x61626380, 14 zero words, then 0x00000018 at widx 15 with out_last_blk=1.
- Empty message (in_last, nbytes=0) → 0x80000000, 14 zero words, then 0x00000000 with out_last_blk=1; exactly 16 words.
- 14 full words, last with nbytes=4 (56 bytes) → data at widx 0..13, 0x80000000 at 14, 0 at 15, then a second block of 15 zeros and 0x000001C0 at widx 15. out_last_blk is asserted only once.
- 16 full words (64 bytes) → block 1 is pure data; block 2 has 0x80000000 at widx 0, zeros, and 0x00000200 at widx 15.
- Random out_ready (50%) replaying test 1 → identical word sequence, out_data stable during every stall, and in_ready never high during a stall.
- WORD_W=64: "abc" → 0x6162638000000000, 14 zeros, then 0x18 at widx 15.
  - Then assert rst after 5 words of a new message, release, resend "abc" → identical single block.
